// File: rtl/ifu_pkg.sv
// ----------------------------------------------------------------------------
// ifu_pkg
// Shared types and constants for the instruction fetch unit.
//   ifu_state_e  : fetch FSM states
//   ifu_fault_e  : sticky fault cause codes presented on fault_cause
//   RRESP_OKAY   : the only read response that counts as a good fetch
//   count_width  : width of the timeout counter for a given TIMEOUT value
// ----------------------------------------------------------------------------
package ifu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        FAULT
    } ifu_state_e;

    typedef enum logic [1:0] {
        NONE     = 2'd0,
        MISALIGN = 2'd1,
        BUS_ERR  = 2'd2,
        TIMEOUT  = 2'd3
    } ifu_fault_e;

    localparam logic [1:0] RRESP_OKAY = 2'b00;

    // A counter that must be able to hold the value TIMEOUT needs
    // clog2(TIMEOUT+1) bits; a disabled timeout still gets one bit so that
    // no zero-width vector is ever declared.
    function automatic int count_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/ifu_timeout.sv
// ----------------------------------------------------------------------------
// ifu_timeout
// Clearable saturating cycle counter that watches how long a fetch has been
// outstanding on the bus.
//   clk, rst  : clock, synchronous active-high reset
//   clear     : forces the count back to zero (held while no fetch is pending)
//   enable    : count this cycle
//   expired   : the current cycle is the TIMEOUT-th counted cycle (or later)
// With TIMEOUT == 0 the counter is not built and expired is tied low.
// ----------------------------------------------------------------------------
module ifu_timeout #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    import ifu_pkg::*;

    localparam int CW = count_width(TIMEOUT);

    generate
        if (TIMEOUT > 0) begin : g_count
            localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
            localparam logic [CW-1:0] LAST  = CW'(TIMEOUT - 1);

            logic [CW-1:0] count;

            // The count holds the number of cycles already spent waiting, so
            // during the n-th waiting cycle it reads n-1. Saturating at LIMIT
            // keeps it from wrapping while the FSM finishes a late handshake.
            always_ff @(posedge clk) begin
                if (rst || clear) begin
                    count <= '0;
                end else if (enable && (count != LIMIT)) begin
                    count <= count + CW'(1);
                end
            end

            // Flag the cycle that would be the TIMEOUT-th one, so the FSM can
            // still let a handshake in that same cycle win over the fault.
            assign expired = (count >= LAST);
        end else begin : g_off
            logic unused_inputs;
            assign unused_inputs = clk ^ rst ^ clear ^ enable;
            assign expired       = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/ifu.sv
// ----------------------------------------------------------------------------
// ifu
// Instruction fetch unit. Reads the current PC, issues one read on the
// AXI-lite AR/R subset, latches the returned word and hands it to
// decode/execute. Consuming the instruction pulses pc_wen so the PC register
// advances exactly once per retired instruction. Any fault stops fetching
// until reset.
//   clk, rst                         : clock, synchronous active-high reset
//   pc / pc_wen                      : PC register output / its write enable
//   arvalid, araddr, arready         : read address channel
//   rvalid, rdata, rresp, rready     : read data channel
//   inst_valid, inst, inst_pc,
//   inst_ready                       : instruction handed downstream
//   fault, fault_cause               : sticky fault flag and its cause
// ----------------------------------------------------------------------------
module ifu #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_WIDTH-1:0] pc,
    output logic                  pc_wen,

    output logic                  arvalid,
    output logic [ADDR_WIDTH-1:0] araddr,
    input  logic                  arready,

    input  logic                  rvalid,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    output logic                  rready,

    output logic                  inst_valid,
    output logic [DATA_WIDTH-1:0] inst,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    input  logic                  inst_ready,

    output logic                  fault,
    output logic [1:0]            fault_cause
);
    // The module parameter TIMEOUT shadows the fault code of the same name,
    // so the fault code is always written package-qualified below.
    import ifu_pkg::*;

    ifu_state_e state;
    ifu_fault_e cause_q;

    logic aligned;
    logic in_flight;
    logic expired;

    assign aligned   = (pc[1:0] == 2'b00);
    assign in_flight = (state == REQ) || (state == WAIT);

    // The counter is held at zero whenever no read is pending, which makes
    // it start from zero on every entry into REQ.
    ifu_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (!in_flight),
        .enable  (in_flight),
        .expired (expired)
    );

    // Fetch FSM plus the instruction/PC latches and the sticky fault
    // registers. Within REQ a misaligned PC is reported before anything else
    // because no read is ever issued for it; in REQ and WAIT a completing
    // handshake is checked ahead of the timeout so it wins a tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            inst    <= '0;
            inst_pc <= '0;
            fault   <= 1'b0;
            cause_q <= NONE;
        end else begin
            case (state)
                IDLE: begin
                    state <= REQ;
                end
                REQ: begin
                    if (!aligned) begin
                        state   <= FAULT;
                        fault   <= 1'b1;
                        cause_q <= MISALIGN;
                    end else if (arready) begin
                        state <= WAIT;
                    end else if (expired) begin
                        state   <= FAULT;
                        fault   <= 1'b1;
                        cause_q <= ifu_pkg::TIMEOUT;
                    end
                end
                WAIT: begin
                    if (rvalid) begin
                        if (rresp == RRESP_OKAY) begin
                            inst    <= rdata;
                            inst_pc <= pc;
                            state   <= HOLD;
                        end else begin
                            state   <= FAULT;
                            fault   <= 1'b1;
                            cause_q <= BUS_ERR;
                        end
                    end else if (expired) begin
                        state   <= FAULT;
                        fault   <= 1'b1;
                        cause_q <= ifu_pkg::TIMEOUT;
                    end
                end
                HOLD: begin
                    if (inst_ready) begin
                        state <= REQ;
                    end
                end
                FAULT: begin
                    state <= FAULT;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Handshake outputs are decoded from the registered state. The PC is
    // only written from HOLD, so it cannot move while a read is pending and
    // araddr can follow it directly.
    assign araddr      = pc;
    assign arvalid     = (state == REQ) && aligned;
    assign rready      = (state == WAIT);
    assign inst_valid  = (state == HOLD);
    assign pc_wen      = inst_valid && inst_ready;
    assign fault_cause = cause_q;

endmodule

// File: tb/tb_ifu.sv
// ----------------------------------------------------------------------------
// tb_ifu
// Self-checking bench for ifu. Each fetch is described by its address, the
// memory delays (arready, rvalid) and the consumer delay (inst_ready); the
// bench works out from those numbers which cycle each handshake lands on and
// how the fetch ends (retire, misalign, bus error, timeout or reset), then
// compares the DUT outputs cycle by cycle. The bench plays the PC register.
// ----------------------------------------------------------------------------
module tb_ifu;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int T  = 8;

    localparam int RETIRED  = 0;
    localparam int MISALIGN = 1;
    localparam int BUSERR   = 2;
    localparam int TIMEDOUT = 3;
    localparam int WASRESET = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] pc;
    logic          pc_wen;
    logic          arvalid;
    logic [AW-1:0] araddr;
    logic          arready;
    logic          rvalid;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rready;
    logic          inst_valid;
    logic [DW-1:0] inst;
    logic [AW-1:0] inst_pc;
    logic          inst_ready;
    logic          fault;
    logic [1:0]    fault_cause;

    int checkCount = 0;
    int passCount  = 0;

    logic [DW-1:0] lastInst;
    logic [AW-1:0] lastInstPc;
    logic [AW-1:0] curPc;

    always #5 clk = ~clk;

    ifu #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (T)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .pc_wen      (pc_wen),
        .arvalid     (arvalid),
        .araddr      (araddr),
        .arready     (arready),
        .rvalid      (rvalid),
        .rdata       (rdata),
        .rresp       (rresp),
        .rready      (rready),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready),
        .fault       (fault),
        .fault_cause (fault_cause)
    );

    // Count one comparison and report it when the DUT disagrees.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                     tag, observed, expected, $time);
        end
    endtask

    // Drive every bus/consumer input for the coming cycle.
    task automatic applyStimulus(input logic ar, input logic rv,
                                 input logic [1:0] resp, input logic [DW-1:0] data,
                                 input logic ir);
        arready    = ar;
        rvalid     = rv;
        rresp      = resp;
        rdata      = data;
        inst_ready = ir;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_arvalid"},     64'(arvalid),     64'd0);
        checkOutput({tag, "_rready"},      64'(rready),      64'd0);
        checkOutput({tag, "_inst_valid"},  64'(inst_valid),  64'd0);
        checkOutput({tag, "_pc_wen"},      64'(pc_wen),      64'd0);
        checkOutput({tag, "_fault"},       64'(fault),       64'd0);
        checkOutput({tag, "_fault_cause"}, 64'(fault_cause), 64'd0);
        checkOutput({tag, "_inst"},        64'(inst),        64'd0);
        checkOutput({tag, "_inst_pc"},     64'(inst_pc),     64'd0);
    endtask

    // Release reset and check the idle cycle; inst_ready is held high to
    // show pc_wen cannot fire outside a held instruction.
    task automatic resetTail(input string tag);
        rst = 1'b0;
        applyStimulus(1'($urandom), 1'($urandom), 2'($urandom), $urandom, 1'b1);
        #1;
        checkResetValues(tag);
        lastInst   = '0;
        lastInstPc = '0;
        nextCycle();
    endtask

    task automatic doReset(input string tag);
        rst = 1'b1;
        applyStimulus(1'($urandom), 1'($urandom), 2'($urandom), $urandom, 1'($urandom));
        nextCycle();
        resetTail(tag);
    endtask

    // A faulted unit must sit still regardless of what the bus or consumer do.
    task automatic checkFaultHold(input int cause);
        for (int c = 0; c < 3; c++) begin
            pc = $urandom;
            applyStimulus(1'($urandom), 1'($urandom), 2'($urandom), $urandom, 1'b1);
            #1;
            checkOutput("fault_flag",    64'(fault),       64'd1);
            checkOutput("fault_cause",   64'(fault_cause), 64'(cause));
            checkOutput("fault_arvalid", 64'(arvalid),     64'd0);
            checkOutput("fault_rready",  64'(rready),      64'd0);
            checkOutput("fault_ivalid",  64'(inst_valid),  64'd0);
            checkOutput("fault_pc_wen",  64'(pc_wen),      64'd0);
            checkOutput("fault_inst",    64'(inst),        64'(lastInst));
            checkOutput("fault_inst_pc", 64'(inst_pc),     64'(lastInstPc));
            nextCycle();
        end
    endtask

    // One fetch starting in a cycle where the unit should be requesting.
    // a/r/d: cycles of delay before arready/rvalid/inst_ready go high.
    // rstAt: hold cycle in which reset is pulsed, or -1 for none.
    task automatic runFetch(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input int a, input int r, input int d,
                            input logic [1:0] resp, input int rstAt,
                            output int outcome);
        int used;
        bit done;
        used    = 0;
        done    = 1'b0;
        outcome = RETIRED;
        pc      = addr;

        if (addr[1:0] != 2'b00) begin
            applyStimulus(1'($urandom), 1'($urandom), 2'($urandom), $urandom, 1'($urandom));
            #1;
            checkOutput("mis_arvalid", 64'(arvalid), 64'd0);
            checkOutput("mis_pc_wen",  64'(pc_wen),  64'd0);
            nextCycle();
            outcome = MISALIGN;
            return;
        end

        // Address phase; rvalid is waved about to show it is ignored here.
        for (int k = 0; k < 1000 && !done; k++) begin
            applyStimulus(1'(k == a), 1'($urandom), 2'b10, $urandom, 1'($urandom));
            #1;
            checkOutput("req_arvalid", 64'(arvalid),    64'd1);
            checkOutput("req_araddr",  64'(araddr),     64'(addr));
            checkOutput("req_rready",  64'(rready),     64'd0);
            checkOutput("req_ivalid",  64'(inst_valid), 64'd0);
            checkOutput("req_pc_wen",  64'(pc_wen),     64'd0);
            used++;
            nextCycle();
            if (k == a) done = 1'b1;
            else if (used >= T) begin
                outcome = TIMEDOUT;
                return;
            end
        end

        // Data phase.
        done = 1'b0;
        for (int j = 0; j < 1000 && !done; j++) begin
            applyStimulus(1'($urandom), 1'(j == r), (j == r) ? resp : 2'($urandom),
                          (j == r) ? data : $urandom, 1'($urandom));
            #1;
            checkOutput("wait_rready",  64'(rready),     64'd1);
            checkOutput("wait_arvalid", 64'(arvalid),    64'd0);
            checkOutput("wait_ivalid",  64'(inst_valid), 64'd0);
            checkOutput("wait_pc_wen",  64'(pc_wen),     64'd0);
            used++;
            nextCycle();
            if (j == r) begin
                if (resp != 2'b00) begin
                    outcome = BUSERR;
                    return;
                end
                done = 1'b1;
            end else if (used >= T) begin
                outcome = TIMEDOUT;
                return;
            end
        end

        lastInst   = data;
        lastInstPc = addr;

        // Hold phase until the consumer takes the instruction.
        done = 1'b0;
        for (int h = 0; h < 1000 && !done; h++) begin
            if (h == rstAt) begin
                rst = 1'b1;
                applyStimulus(1'($urandom), 1'($urandom), 2'($urandom), $urandom, 1'b0);
                #1;
                checkOutput("rsthold_ivalid", 64'(inst_valid), 64'd1);
                nextCycle();
                resetTail("rsthold");
                outcome = WASRESET;
                return;
            end
            applyStimulus(1'($urandom), 1'($urandom), 2'($urandom), $urandom, 1'(h == d));
            #1;
            checkOutput("hold_ivalid",  64'(inst_valid), 64'd1);
            checkOutput("hold_inst",    64'(inst),       64'(data));
            checkOutput("hold_inst_pc", 64'(inst_pc),    64'(addr));
            checkOutput("hold_pc_wen",  64'(pc_wen),     64'(h == d));
            checkOutput("hold_arvalid", 64'(arvalid),    64'd0);
            checkOutput("hold_rready",  64'(rready),     64'd0);
            nextCycle();
            if (h == d) done = 1'b1;
        end
    endtask

    // Run a fetch, follow up on any fault, and advance the bench's PC
    // register only when the instruction retired.
    task automatic fetchAndCheck(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                                 input int a, input int r, input int d,
                                 input logic [1:0] resp, input int rstAt);
        int outcome;
        runFetch(addr, data, a, r, d, resp, rstAt, outcome);
        case (outcome)
            RETIRED: curPc = addr + 32'd4;
            MISALIGN, BUSERR, TIMEDOUT: begin
                checkFaultHold(outcome);
                doReset("postfault");
                if (outcome == MISALIGN) curPc = {addr[AW-1:2], 2'b00} + 32'd4;
            end
            default: ;
        endcase
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        pc  = 32'h8000_0000;
        applyStimulus(1'b0, 1'b0, 2'b00, '0, 1'b0);
        @(negedge clk);
        doReset("reset");

        // Zero-wait stream, then backpressure.
        fetchAndCheck(32'h8000_0000, 32'h0000_0513, 0, 0, 0, 2'b00, -1);
        fetchAndCheck(32'h8000_0004, 32'h0010_0073, 0, 0, 0, 2'b00, -1);
        fetchAndCheck(32'h8000_0008, 32'h1234_5678, 4, 3, 2, 2'b00, -1);

        // Timeout boundary: rvalid on the 8th pending cycle still completes.
        fetchAndCheck(32'h8000_000C, 32'hCAFE_0001, 0, 6, 0, 2'b00, -1);
        fetchAndCheck(32'h8000_0010, 32'hCAFE_0002, 5, 1, 1, 2'b00, -1);
        fetchAndCheck(32'h8000_0014, 32'hCAFE_0003, 0, 50, 0, 2'b00, -1);
        fetchAndCheck(32'h8000_0014, 32'hCAFE_0004, 50, 0, 0, 2'b00, -1);

        // Bus error after a good fetch, so the held instruction is non-zero.
        fetchAndCheck(32'h8000_0020, 32'h0badf00d, 1, 1, 0, 2'b00, -1);
        fetchAndCheck(32'h8000_0024, 32'hDEAD_BEEF, 0, 2, 0, 2'b10, -1);

        // Misaligned PC.
        fetchAndCheck(32'h8000_0030, 32'h1111_2222, 0, 0, 0, 2'b00, -1);
        fetchAndCheck(32'h8000_0002, 32'h3333_4444, 0, 0, 0, 2'b00, -1);

        // Reset while holding, then the same PC is fetched again.
        fetchAndCheck(32'h8000_0040, 32'h5555_6666, 0, 0, 3, 2'b00, 1);
        fetchAndCheck(32'h8000_0040, 32'h7777_8888, 0, 0, 0, 2'b00, -1);

        // Random traffic.
        curPc = 32'h8000_1000;
        for (int n = 0; n < 80; n++) begin
            logic [AW-1:0] addr;
            logic [1:0]    resp;
            int            a, r, d, rstAt;
            a     = $urandom_range(0, 4);
            r     = $urandom_range(0, 4);
            d     = $urandom_range(0, 3);
            resp  = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            rstAt = ($urandom_range(0, 19) == 0) ? $urandom_range(0, d) : -1;
            addr  = curPc;
            if ($urandom_range(0, 14) == 0) addr[1:0] = 2'($urandom_range(1, 3));
            fetchAndCheck(addr, $urandom, a, r, d, resp, rstAt);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
